// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing controller for a MIPS-subset datapath.
// Walks IF/ID/EXE/MEM/WB, shares one memory port, counts retirements, flags illegal opcodes.
module multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [5:0]       Op,
    input  logic [5:0]       Func,
    input  logic             Z,
    input  logic             Mem_ready,
    output logic             Mrd,
    output logic             Wmem,
    output logic             Iord,
    output logic             Irwrite,
    output logic             Pcwrite,
    output logic [1:0]       Pcsrc,
    output logic             Regrt,
    output logic             Se,
    output logic             Aluqb,
    output logic [1:0]       Aluc,
    output logic             Wreg,
    output logic             Reg2reg,
    output logic             Illegal,
    output logic [2:0]       State,
    output logic [CNT_W-1:0] Instr_count
);

    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EXE = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;

    logic [2:0] state_q, state_d;
    logic r_type, r_add, r_sub, r_and, r_or;
    logic i_addi, i_andi, i_ori, i_lw, i_sw, i_beq, i_bne, i_j;
    logic legal, is_branch;
    logic mrd_c, wmem_c, irwrite_c, pcwrite_c, wreg_c, retire;

    always_comb begin
        r_type  = (Op == 6'b000000);
        r_add   = r_type && (Func == 6'b100000);
        r_sub   = r_type && (Func == 6'b100010);
        r_and   = r_type && (Func == 6'b100100);
        r_or    = r_type && (Func == 6'b100101);
        i_addi  = (Op == 6'b001000);
        i_andi  = (Op == 6'b001100);
        i_ori   = (Op == 6'b001101);
        i_lw    = (Op == 6'b100011);
        i_sw    = (Op == 6'b101011);
        i_beq   = (Op == 6'b000100);
        i_bne   = (Op == 6'b000101);
        i_j     = (Op == 6'b000010);
        is_branch = i_beq || i_bne;
        legal   = r_add || r_sub || r_and || r_or || i_addi || i_andi || i_ori
                  || i_lw || i_sw || is_branch || i_j;
        Regrt   = !r_type;
        Se      = !(i_andi || i_ori);
        Aluqb   = r_type || is_branch;
        Reg2reg = i_lw;
        if (r_and || i_andi)               Aluc = 2'b10;
        else if (r_or || i_ori)            Aluc = 2'b11;
        else if (r_sub || is_branch)       Aluc = 2'b01;
        else                               Aluc = 2'b00;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= S_IF;
        else       state_q <= state_d;
    end

    // Memory handshake: Mrd/Wmem is held while Mem_ready is low; the access
    // completes on the cycle Mem_ready is high. Mem_ready is ignored elsewhere.
    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:    state_d = Mem_ready ? S_ID : S_IF;
            S_ID:    state_d = (i_j || !legal) ? S_IF : S_EXE;
            S_EXE: begin
                if (is_branch)          state_d = S_IF;
                else if (i_lw || i_sw)  state_d = S_MEM;
                else                    state_d = S_WB;
            end
            S_MEM: begin
                if (!Mem_ready)         state_d = S_MEM;
                else if (i_lw)          state_d = S_WB;
                else                    state_d = S_IF;
            end
            S_WB:    state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    always_comb begin
        mrd_c     = 1'b0;
        wmem_c    = 1'b0;
        Iord      = 1'b0;
        irwrite_c = 1'b0;
        pcwrite_c = 1'b0;
        Pcsrc     = 2'b00;
        wreg_c    = 1'b0;
        retire    = 1'b0;
        case (state_q)
            S_IF: begin
                mrd_c = 1'b1;
                if (Mem_ready) begin
                    irwrite_c = 1'b1;
                    pcwrite_c = 1'b1;
                end
            end
            S_ID: begin
                if (i_j) begin
                    pcwrite_c = 1'b1;
                    Pcsrc     = 2'b10;
                    retire    = 1'b1;
                end
            end
            S_EXE: begin
                if (is_branch) begin
                    pcwrite_c = (i_beq && Z) || (i_bne && !Z);
                    Pcsrc     = 2'b01;
                    retire    = 1'b1;
                end
            end
            S_MEM: begin
                Iord = 1'b1;
                if (i_lw)      mrd_c  = 1'b1;
                else if (i_sw) wmem_c = 1'b1;
                retire = i_sw && Mem_ready;
            end
            S_WB: begin
                wreg_c = 1'b1;
                retire = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)       Instr_count <= '0;
        else if (retire) Instr_count <= Instr_count + CNT_W'(1);
    end

    // Reset masks every write strobe so an aborted instruction has no side effects.
    assign Mrd     = mrd_c && !Reset;
    assign Wmem    = wmem_c && !Reset;
    assign Irwrite = irwrite_c && !Reset;
    assign Pcwrite = pcwrite_c && !Reset;
    assign Wreg    = wreg_c && !Reset;
    assign Illegal = (state_q == S_ID) && !legal && !Reset;
    assign State   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: random instruction stream with per-instruction
// summaries predicted from the instruction rules and compared by a monitor.
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic [5:0]       Op = '0, Func = '0;
    logic             Z = 1'b0, Mem_ready = 1'b1;
    logic             Mrd, Wmem, Iord, Irwrite, Pcwrite, Regrt, Se, Aluqb, Wreg, Reg2reg, Illegal;
    logic [1:0]       Pcsrc, Aluc;
    logic [2:0]       State;
    logic [CNT_W-1:0] Instr_count;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .Op(Op), .Func(Func), .Z(Z), .Mem_ready(Mem_ready),
        .Mrd(Mrd), .Wmem(Wmem), .Iord(Iord), .Irwrite(Irwrite), .Pcwrite(Pcwrite),
        .Pcsrc(Pcsrc), .Regrt(Regrt), .Se(Se), .Aluqb(Aluqb), .Aluc(Aluc), .Wreg(Wreg),
        .Reg2reg(Reg2reg), .Illegal(Illegal), .State(State), .Instr_count(Instr_count)
    );

    // ---------------- clock / reset ----------------
    always #5 Clk = ~Clk;

    typedef enum int {I_ADD, I_SUB, I_AND, I_OR, I_ADDI, I_ANDI, I_ORI,
                      I_LW, I_SW, I_BEQ, I_BNE, I_J, I_BAD_OP, I_BAD_FUNC} kind_t;

    typedef struct packed {
        logic [7:0]       cycles;
        logic [4:0]       visited;
        logic [3:0]       mrd_n, wmem_n, iord_n, wreg_n, pcw_n, irw_n, ill_n;
        logic [1:0]       pcsrc_or;
        logic             dc;
        logic             regrt, se, aluqb, reg2reg;
        logic [1:0]       aluc;
        logic [CNT_W-1:0] count;
    } rec_t;
    localparam int W = $bits(rec_t);

    logic [W-1:0]     exp_q[$];
    int               checks = 0;
    int               failures = 0;
    logic [CNT_W-1:0] model_count = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic encode(input kind_t k, input int variant, output logic [5:0] op, output logic [5:0] fn);
        logic [5:0] bad_ops [4];
        logic [5:0] bad_fns [4];
        bad_ops = '{6'b111111, 6'b000001, 6'b000011, 6'b100000};
        bad_fns = '{6'b000000, 6'b100001, 6'b101010, 6'b111111};
        op = 6'b000000;
        fn = 6'($urandom_range(0, 63));
        case (k)
            I_ADD:      fn = 6'b100000;
            I_SUB:      fn = 6'b100010;
            I_AND:      fn = 6'b100100;
            I_OR:       fn = 6'b100101;
            I_ADDI:     op = 6'b001000;
            I_ANDI:     op = 6'b001100;
            I_ORI:      op = 6'b001101;
            I_LW:       op = 6'b100011;
            I_SW:       op = 6'b101011;
            I_BEQ:      op = 6'b000100;
            I_BNE:      op = 6'b000101;
            I_J:        op = 6'b000010;
            I_BAD_OP:   op = bad_ops[variant % 4];
            default:    fn = bad_fns[variant % 4];
        endcase
    endtask

    function automatic rec_t model(input kind_t k, input logic z, input int a, input int b,
                                   input logic [CNT_W-1:0] cnt);
        rec_t r;
        bit rt, alu, lw, sw, br, j, ill, taken, mem, wb, exe;
        r     = '0;
        rt    = (k <= I_OR);
        alu   = (k <= I_ORI);
        lw    = (k == I_LW);
        sw    = (k == I_SW);
        br    = (k == I_BEQ) || (k == I_BNE);
        j     = (k == I_J);
        ill   = (k == I_BAD_OP) || (k == I_BAD_FUNC);
        taken = ((k == I_BEQ) && z) || ((k == I_BNE) && !z);
        mem   = lw || sw;
        wb    = alu || lw;
        exe   = !(j || ill);
        if (j || ill)  r.cycles = 8'(a + 2);
        else if (br)   r.cycles = 8'(a + 3);
        else if (alu)  r.cycles = 8'(a + 4);
        else if (lw)   r.cycles = 8'(a + b + 5);
        else           r.cycles = 8'(a + b + 4);
        r.visited  = {wb, mem, exe, 1'b1, 1'b1};
        r.mrd_n    = 4'(a + 1 + (lw ? b + 1 : 0));
        r.wmem_n   = 4'(sw ? b + 1 : 0);
        r.iord_n   = 4'(mem ? b + 1 : 0);
        r.wreg_n   = 4'(wb);
        r.pcw_n    = 4'(1 + int'(j) + int'(taken));
        r.irw_n    = 4'd1;
        r.ill_n    = 4'(ill);
        r.pcsrc_or = j ? 2'b10 : (taken ? 2'b01 : 2'b00);
        r.dc       = ill;
        r.regrt    = !rt;
        r.se       = !((k == I_ANDI) || (k == I_ORI));
        r.aluqb    = rt || br;
        r.reg2reg  = lw;
        if (k == I_AND || k == I_ANDI)      r.aluc = 2'b10;
        else if (k == I_OR || k == I_ORI)   r.aluc = 2'b11;
        else if (k == I_SUB || br)          r.aluc = 2'b01;
        else                                r.aluc = 2'b00;
        r.count = cnt + CNT_W'(ill ? 0 : 1);
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    // Called at posedge+1; the first driven cycle is the instruction's first IF cycle.
    task automatic run_instr(input kind_t k, input int variant, input logic z, input int a, input int b);
        logic [5:0] op, fn;
        rec_t r;
        bit mem;
        int mem_start;
        encode(k, variant, op, fn);
        r = model(k, z, a, b, model_count);
        exp_q.push_back(W'(r));
        model_count = r.count;
        mem = (k == I_LW) || (k == I_SW);
        mem_start = a + 3;
        for (int c = 0; c < int'(r.cycles); c++) begin
            Op = op; Func = fn; Z = z;
            if (c < a)                         Mem_ready = 1'b0;
            else if (c == a)                   Mem_ready = 1'b1;
            else if (mem && c >= mem_start)    Mem_ready = (c == mem_start + b);
            else                               Mem_ready = 1'($urandom_range(0, 1));
            @(posedge Clk); #1;
        end
    endtask

    task automatic sw_abort();
        Op = 6'b101011; Func = '0; Z = 1'b0;
        for (int c = 0; c < 4; c++) begin
            Mem_ready = (c == 0) ? 1'b1 : ((c == 3) ? 1'b0 : 1'($urandom_range(0, 1)));
            @(posedge Clk); #1;
        end
        Mem_ready = 1'b0;
        #2;
        check("abort_pre_wmem", 32'(Wmem), 32'd1);
        check("abort_pre_state", 32'(State), 32'd3);
        Reset = 1'b1;
        #1;
        check("abort_wmem", 32'(Wmem), 32'd0);
        check("abort_mrd", 32'(Mrd), 32'd0);
        check("abort_state", 32'(State), 32'd0);
        check("abort_count", 32'(Instr_count), 32'd0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        model_count = '0;
    endtask

    // ---------------- scoreboard monitor ----------------
    rec_t       cur = '0;
    bit         have_rec = 0;
    logic [2:0] prev_state = 3'd7;
    int         retired_seen = 0;

    task automatic finish_rec();
        rec_t act, req;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_instr actual=%h required=none", cur);
            return;
        end
        req = rec_t'(exp_q.pop_front());
        act = cur;
        act.count = Instr_count;
        act.dc = req.dc;
        if (req.dc) begin
            act.regrt = req.regrt; act.se = req.se; act.aluqb = req.aluqb;
            act.reg2reg = req.reg2reg; act.aluc = req.aluc;
        end
        if (act !== req) begin
            failures++;
            $display("FAIL instr_%0d actual=%h required=%h", retired_seen, act, req);
        end
        retired_seen++;
    endtask

    always @(negedge Clk) begin
        if (Reset) begin
            have_rec = 0;
            prev_state = 3'd7;
        end else begin
            if (State == 3'd0 && prev_state != 3'd0) begin
                if (have_rec) finish_rec();
                cur = '0;
                have_rec = 1;
            end
            cur.cycles = cur.cycles + 8'd1;
            if (State < 3'd5) cur.visited[State] = 1'b1;
            cur.mrd_n  = cur.mrd_n + 4'(Mrd);
            cur.wmem_n = cur.wmem_n + 4'(Wmem);
            cur.iord_n = cur.iord_n + 4'((Mrd || Wmem) && Iord);
            cur.wreg_n = cur.wreg_n + 4'(Wreg);
            cur.pcw_n  = cur.pcw_n + 4'(Pcwrite);
            cur.irw_n  = cur.irw_n + 4'(Irwrite);
            cur.ill_n  = cur.ill_n + 4'(Illegal);
            if (Pcwrite) cur.pcsrc_or = cur.pcsrc_or | Pcsrc;
            if (State == 3'd1) begin
                cur.regrt = Regrt; cur.se = Se; cur.aluqb = Aluqb;
                cur.reg2reg = Reg2reg; cur.aluc = Aluc;
            end
            prev_state = State;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(posedge Clk);
        #1;
        check("rst_state", 32'(State), 32'd0);
        check("rst_count", 32'(Instr_count), 32'd0);
        check("rst_illegal", 32'(Illegal), 32'd0);
        check("rst_mrd", 32'(Mrd), 32'd0);
        check("rst_irwrite", 32'(Irwrite), 32'd0);
        check("rst_pcwrite", 32'(Pcwrite), 32'd0);
        check("rst_wreg", 32'(Wreg), 32'd0);
        Reset = 1'b0;

        run_instr(I_ADD, 0, 1'b0, 0, 0);
        run_instr(I_LW, 0, 1'b0, 2, 2);
        run_instr(I_BEQ, 0, 1'b1, 0, 0);
        run_instr(I_BEQ, 0, 1'b0, 0, 0);
        run_instr(I_J, 0, 1'b0, 0, 0);
        run_instr(I_SW, 0, 1'b0, 0, 0);
        run_instr(I_BAD_OP, 0, 1'b0, 0, 0);
        run_instr(I_BAD_FUNC, 1, 1'b0, 1, 0);
        for (int i = 0; i < 20; i++) run_instr(I_ADDI, 0, 1'b0, 0, 0);

        for (int i = 0; i < 60; i++)
            run_instr(kind_t'($urandom_range(0, 13)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));

        sw_abort();

        for (int i = 0; i < 20; i++)
            run_instr(kind_t'($urandom_range(0, 13)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));

        Mem_ready = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("drain_expected_queue", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencing controller for the MIPS-subset CPU datapath: add, sub, and, or, addi, andi, ori, lw, sw, beq, bne, j.
- Walks each instruction through IF/ID/EXE/MEM/WB states and drives per-state datapath strobes.
- Shares one memory port between instruction fetch and data access, waiting on a memory ready handshake.
- Counts retired instructions and flags illegal opcodes.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Op  input  6  opcode from the external instruction register (stable from ID onward).
- Func  input  6  function field from the instruction register.
- Z  input  1  ALU zero flag (combinational, valid in EXE).
- Mem_ready  input  1  memory handshake: the access completes on a cycle when this is high.
- Mrd  output  1  memory read request.
- Wmem  output  1  memory write request.
- Iord  output  1  memory address select: 0 = PC, 1 = ALU result.
- Irwrite  output  1  load the instruction register.
- Pcwrite  output  1  load the PC.
- Pcsrc  output  2  PC source: 00 = PC+4, 01 = branch target, 10 = jump target.
- Regrt  output  1  destination register is rt (1) or rd (0).
- Se  output  1  1 = sign-extend immediate, 0 = zero-extend.
- Aluqb  output  1  ALU B operand: 1 = register, 0 = immediate.
- Aluc  output  2  ALU op: 00 add, 01 sub, 10 and, 11 or.
- Wreg  output  1  register file write enable.
- Reg2reg  output  1  writeback source: 1 = memory data, 0 = ALU result.
- Illegal  output  1  one-cycle pulse when an undefined instruction is decoded.
- State  output  3  current state: IF=0, ID=1, EXE=2, MEM=3, WB=4.
- Instr_count  output  CNT_W  number of retired instructions.

Behaviour:
- Decode (combinational from Op/Func):
  - R-type: Op=000000 with Func 100000 add, 100010 sub, 100100 and, 100101 or.
  - I-type opcodes: addi 001000, andi 001100, ori 001101, lw 100011, sw 101011, beq 000100, bne 000101, j 000010.
  - Any other Op, or R-type with an unlisted Func, is illegal.
- Static decode outputs, driven in every state:
  - Regrt = not R-type.
  - Se = 0 for andi/ori, else 1.
  - Aluqb = 1 for R-type, beq, bne.
  - Reg2reg = lw.
  - Aluc: and/andi = 10; or/ori = 11; sub/beq/bne = 01; all others = 00.
- Reset (asynchronous): State = IF, Instr_count = 0, Illegal = 0. While Reset is high, Mrd, Wmem, Irwrite, Pcwrite and Wreg are forced to 0.
- IF:
  - Drive Mrd=1, Iord=0.
  - Stay in IF while Mem_ready=0.
  - On the Mem_ready=1 cycle: Irwrite=1, Pcwrite=1, Pcsrc=00, next state ID.
- ID (1 cycle):
  - j: Pcwrite=1, Pcsrc=10, Instr_count++, next IF.
  - Illegal instruction: Illegal=1, no count, next IF.
  - Otherwise: next EXE.
- EXE (1 cycle):
  - beq/bne: Pcwrite = (beq & Z) | (bne & ~Z), Pcsrc=01, Instr_count++, next IF.
  - lw/sw: next MEM.
  - All other instructions: next WB.
- MEM:
  - Drive Iord=1.
  - lw: Mrd=1, hold until Mem_ready=1, then next WB.
  - sw: Wmem=1, hold until Mem_ready=1; on that cycle Instr_count++, next IF.
  - Mrd and Wmem are never high together.
- WB (1 cycle): Wreg=1, Instr_count++, next IF.
- Latency with Mem_ready tied high:
  - ALU instructions: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/bne: 3 cycles.
  - j: 2 cycles.
- Instr_count wraps from all-ones to 0 silently.
- Undefined State encodings (5-7) return to IF on the next edge.
- Reset asserted mid-instruction aborts it immediately: no write strobe is issued after Reset rises.
- Mem_ready is ignored outside IF and MEM.
- All strobes other than Illegal are combinational from State, decode, Z and Mem_ready.

Test Plan:
- Reset, Mem_ready=1, add (Op=000000, Func=100000) -> State sequence 0,1,2,4,0; Wreg=1 only in WB; Regrt=0, Aluc=00; Instr_count=1.
- lw (100011) with Mem_ready low for 2 cycles in both IF and MEM -> IF held 3 cycles; MEM shows Iord=1, Mrd=1 for 3 cycles; then WB with Reg2reg=1, Wreg=1; total 9 cycles.
- beq with Z=1, then beq with Z=0 -> Pcwrite=1, Pcsrc=01 in EXE for the first only; both add 1 to Instr_count; neither raises Wreg.
- j (000010) -> Pcwrite=1, Pcsrc=10 in ID, returns to IF after 2 cycles; sw (101011) -> Wmem=1, Iord=1 in MEM, Wreg never high.
- Op=111111 -> Illegal pulses 1 cycle in ID, Instr_count unchanged, next state IF.
- Reset asserted during MEM of sw -> Wmem drops to 0 asynchronously, State=0, Instr_count=0; with CNT_W=4, 16 WB retirements -> count wraps to 0.
